alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The module SHALL have parameter BIT_LENGTH, default 8, which is the operand width.
REQ-002 The module SHALL have parameter INSTR_LENGTH, default 20, which is the instruction and result width.
REQ-003 The module SHALL have parameter OPCODE_LENGTH, default 4, which is the opcode width.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single system clock; all state SHALL update on its rising edge only.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-006 Port instr_valid SHALL be an input, 1 bit wide: an instruction word is offered by the SPI receive side.
REQ-007 Port instr SHALL be an input, INSTR_LENGTH bits wide, with the format {opcode[19:16], a[15:8], b[7:0]}.
REQ-008 Port instr_ready SHALL be an output, 1 bit wide: the block can accept an instruction.
REQ-009 Port exec_en SHALL be an output, 1 bit wide: the enable for the ALU.
REQ-010 Port opcode SHALL be an output, OPCODE_LENGTH bits wide: the registered opcode sent to the ALU.
REQ-011 Ports a and b SHALL each be an output, BIT_LENGTH bits wide: the registered operands sent to the ALU.
REQ-012 Port alu_out SHALL be an input, INSTR_LENGTH bits wide: the combinational ALU result.
REQ-013 Port result SHALL be an output, INSTR_LENGTH bits wide: the captured result for the SPI transmit side.
REQ-014 Port result_valid SHALL be an output, 1 bit wide: result is held and valid.
REQ-015 Port result_ready SHALL be an input, 1 bit wide: the transmit side consumes result.
REQ-016 Port err SHALL be an output, 1 bit wide: the current result came from an illegal opcode.
REQ-017 Port instr_cnt SHALL be an output, 8 bits wide: the count of completed instructions.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and HOLD.
REQ-019 instr_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, a handshake (instr_valid & instr_ready) SHALL register opcode, a and b from instr and move the FSM to EXEC.
REQ-021 In IDLE with no handshake, the FSM SHALL stay in IDLE and the registered fields SHALL be unchanged.
REQ-022 In EXEC, exec_en SHALL be 1 for exactly one cycle; alu_out SHALL be captured into result at the end of that cycle; the FSM SHALL then move to HOLD.
REQ-023 exec_en SHALL be 0 in every state other than EXEC, and opcode, a and b SHALL stay stable from acceptance until HOLD is left.
REQ-024 In HOLD, result_valid SHALL be 1 and result and err SHALL be stable.
REQ-025 In HOLD, result_ready=1 SHALL complete the transfer: the FSM returns to IDLE next cycle and result_valid drops.
REQ-026 In HOLD with result_ready=0, the FSM SHALL stay in HOLD indefinitely (backpressure).
REQ-027 Latency: for an instruction accepted in cycle N, exec_en SHALL be 1 in cycle N+1 and result_valid SHALL first be 1 in cycle N+2.
REQ-028 Maximum throughput SHALL be one instruction per 3 cycles when result_ready is held at 1.
REQ-029 result_ready SHALL be ignored outside HOLD, and instr_valid SHALL be ignored outside IDLE (no queuing).
REQ-030 instr_cnt SHALL increment by 1 on each HOLD-to-IDLE transfer and wrap from 255 to 0.
REQ-031 The legal opcodes SHALL be 0000-0111 and 1000; every other opcode is illegal.

Reset
REQ-032 rst=1 at a clock edge SHALL force the FSM to IDLE.
REQ-033 rst=1 at a clock edge SHALL force exec_en, result_valid and err to 0.
REQ-034 rst=1 at a clock edge SHALL force opcode, a, b, result and instr_cnt to 0.
REQ-035 Reset SHALL take priority over any handshake in the same cycle.
REQ-036 Reset asserted in EXEC or HOLD SHALL abort the instruction with no result delivered and no count increment.
REQ-037 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-038 Macro ALU_CTRL_ILLEGAL_CHECK_EN defined: an illegal opcode SHALL still pass through EXEC with exec_en held at 0, result SHALL be captured as 0, and err SHALL be 1 in HOLD.
REQ-039 Macro ALU_CTRL_ILLEGAL_CHECK_EN defined: err SHALL be 0 for legal opcodes.
REQ-040 Macro ALU_CTRL_ILLEGAL_CHECK_EN undefined: all opcodes SHALL be treated as legal, exec_en SHALL pulse normally, alu_out SHALL be captured as-is, and err SHALL be tied to 0.
REQ-041 Timing and count behaviour SHALL be identical whether or not the macro is defined.

Verification
REQ-042 Scenario ADD: instr=0x0_05_03 with result_ready=1 -> exec_en pulse in cycle N+1 with opcode=0, a=0x05, b=0x03; then result=0x00008 with result_valid in N+2; then instr_cnt=1.
REQ-043 Scenario SUB with backpressure: instr=0x8_10_01 with result_ready=0 for 5 cycles -> result=0x0000F held stable with result_valid=1 and instr_ready=0 for all 5 cycles; then release on result_ready=1.
REQ-044 Scenario back-to-back: 4 instructions offered continuously with result_ready=1 -> accepts in cycles 0, 3, 6 and 9, and instr_cnt=4.
REQ-045 Scenario illegal opcode with macro defined: instr=0xF_AA_55 -> exec_en stays 0, result=0, err=1; the next legal instruction gives err=0.
REQ-046 Scenario reset mid-operation: rst=1 during HOLD -> next cycle result_valid=0, instr_ready=1, instr_cnt unchanged and result=0.
REQ-047 Scenario counter wrap: 256 completed instructions -> instr_cnt=0.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Instruction-in / ALU-drive / result-out bundle of the ALU controller.
// slave = controller side, master = SPI + ALU environment side.
interface alu_ctrl_if #(
  parameter int BIT_LENGTH    = 8,
  parameter int INSTR_LENGTH  = 20,
  parameter int OPCODE_LENGTH = 4
);
  logic                     instr_valid;
  logic [INSTR_LENGTH-1:0]  instr;
  logic                     instr_ready;
  logic                     exec_en;
  logic [OPCODE_LENGTH-1:0] opcode;
  logic [BIT_LENGTH-1:0]    a;
  logic [BIT_LENGTH-1:0]    b;
  logic [INSTR_LENGTH-1:0]  alu_out;
  logic [INSTR_LENGTH-1:0]  result;
  logic                     result_valid;
  logic                     result_ready;
  logic                     err;
  logic [7:0]               instr_cnt;

  modport slave (
    input  instr_valid, instr, alu_out, result_ready,
    output instr_ready, exec_en, opcode, a, b, result, result_valid, err, instr_cnt
  );

  modport master (
    output instr_valid, instr, alu_out, result_ready,
    input  instr_ready, exec_en, opcode, a, b, result, result_valid, err, instr_cnt
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequences one instruction at a time through an external ALU: IDLE -> EXEC -> HOLD.
// Latency: accept in N, exec_en in N+1, result_valid from N+2; one instruction per 3 cycles max.
// Backpressure: HOLD waits on result_ready; instr_ready only in IDLE. ALU_CTRL_ILLEGAL_CHECK_EN enables err.
module alu_ctrl #(
  parameter int BIT_LENGTH    = 8,
  parameter int INSTR_LENGTH  = 20,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_q,  state_d;
  logic [OPCODE_LENGTH-1:0] opcode_q, opcode_d;
  logic [BIT_LENGTH-1:0]    a_q,      a_d;
  logic [BIT_LENGTH-1:0]    b_q,      b_d;
  logic [INSTR_LENGTH-1:0]  result_q, result_d;
  logic [7:0]               cnt_q,    cnt_d;
  logic                     op_legal;

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
  logic                     err_q,    err_d;

  // Legal opcodes are 0..7 plus 8 (subtract).
  assign op_legal = (opcode_q <= OPCODE_LENGTH'(8));
`else
  assign op_legal = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          state_d  = EXEC;
          opcode_d = bus.instr[INSTR_LENGTH-1 -: OPCODE_LENGTH];
          a_d      = bus.instr[2*BIT_LENGTH-1 -: BIT_LENGTH];
          b_d      = bus.instr[BIT_LENGTH-1:0];
        end
      end
      EXEC: begin
        state_d  = HOLD;
        result_d = op_legal ? bus.alu_out : '0;
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
        err_d    = ~op_legal;
`endif
      end
      HOLD: begin
        if (bus.result_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Illegal opcodes still walk through EXEC so timing never depends on the opcode.
  assign bus.instr_ready  = (state_q == IDLE);
  assign bus.exec_en      = (state_q == EXEC) && op_legal;
  assign bus.result_valid = (state_q == HOLD);
  assign bus.opcode       = opcode_q;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.result       = result_q;
  assign bus.instr_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed + random bench for alu_ctrl; a behavioural ALU drives alu_out.
module tb_alu_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;
  logic [19:0] last_result;
  logic        last_err;
  int          last_acc;
  int          acc_t [4];

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  alu_ctrl_if bus ();

  alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      4'd0:    return 20'(x) + 20'(y);
      4'd1:    return 20'(x & y);
      4'd2:    return 20'(x | y);
      4'd3:    return 20'(x ^ y);
      4'd4:    return 20'(x) * 20'(y);
      4'd5:    return 20'(x) << y[2:0];
      4'd6:    return 20'(x >> y[2:0]);
      4'd7:    return 20'(~x);
      4'd8:    return 20'(x) - 20'(y);
      default: return 20'hA5A5A ^ {4'h0, x, y};
    endcase
  endfunction

  always_comb bus.alu_out = alu_fn(bus.opcode, bus.a, bus.b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic run_instr(input logic [19:0] ins, input int stall);
    logic [3:0]  op;
    logic [7:0]  x, y;
    logic        legal, ex;
    logic [19:0] er;
    op = ins[19:16]; x = ins[15:8]; y = ins[7:0];
    legal = (op <= 4'd8);
    ex    = !CHK || legal;
    er    = ex ? alu_fn(op, x, y) : 20'h0;
    chk("idle_rdy", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid  = 1'b1;
    bus.instr        = ins;
    bus.result_ready = (stall == 0);
    last_acc = cyc;
    @(negedge clk);
    chk("exec_en", 32'(bus.exec_en), 32'(ex));
    chk("exec_op", 32'(bus.opcode), 32'(op));
    chk("exec_a", 32'(bus.a), 32'(x));
    chk("exec_b", 32'(bus.b), 32'(y));
    chk("exec_rdy", 32'(bus.instr_ready), 32'd0);
    chk("exec_rv", 32'(bus.result_valid), 32'd0);
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.instr       = 20'($urandom);
    @(negedge clk);
    last_result = bus.result;
    last_err    = bus.err;
    for (int i = 0; i < (stall > 0 ? stall : 1); i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_rv", 32'(bus.result_valid), 32'd1);
      chk("hold_res", 32'(bus.result), 32'(er));
      chk("hold_err", 32'(bus.err), 32'(CHK && !legal));
      chk("hold_rdy", 32'(bus.instr_ready), 32'd0);
      chk("hold_en", 32'(bus.exec_en), 32'd0);
      chk("hold_op", 32'({bus.opcode, bus.a, bus.b}), 32'(ins));
      bus.instr_valid = 1'($urandom_range(0, 1));
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("done_rv", 32'(bus.result_valid), 32'd0);
    chk("done_rdy", 32'(bus.instr_ready), 32'd1);
    chk("done_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    bus.instr_valid = 1'b0;
  endtask

  // Reset with a competing handshake offered; reset must win.
  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = 20'h3_12_34;
    @(negedge clk);
    chk("rst_rdy", 32'(bus.instr_ready), 32'd1);
    chk("rst_en", 32'(bus.exec_en), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fields", 32'({bus.opcode, bus.a, bus.b}), 32'd0);
    chk("rst_res", 32'(bus.result), 32'd0);
    chk("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid  = 1'b0;
    bus.instr        = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    chk("post_rst_rdy", 32'(bus.instr_ready), 32'd1);

    // ADD
    run_instr(20'h0_05_03, 0);
    chk("add_res", 32'(last_result), 32'h00008);
    chk("add_cnt", 32'(bus.instr_cnt), 32'd1);

    // SUB with 5 cycles of backpressure
    run_instr(20'h8_10_01, 5);
    chk("sub_res", 32'(last_result), 32'h0000F);

    // Illegal opcode then a legal one
    run_instr(20'hF_AA_55, 0);
    chk("ill_err", 32'(last_err), 32'(CHK));
    chk("ill_res", 32'(last_result), CHK ? 32'h0 : 32'(alu_fn(4'hF, 8'hAA, 8'h55)));
    run_instr(20'h2_0F_F0, 0);
    chk("legal_err", 32'(last_err), 32'd0);

    // Back-to-back with result_ready held high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(20'($urandom_range(0, 8)) << 16 | 20'($urandom_range(0, 16'hFFFF)), 0);
      acc_t[i] = last_acc;
    end
    for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
    chk("b2b_cnt", 32'(bus.instr_cnt), 32'd4);

    // Reset during HOLD
    do_reset();
    bus.instr_valid  = 1'b1;
    bus.instr        = 20'h1_0F_3C;
    bus.result_ready = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_hold_rv", 32'(bus.result_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rv", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_rdy", 32'(bus.instr_ready), 32'd1);
    chk("mid_rst_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("mid_rst_res", 32'(bus.result), 32'd0);
    rst = 1'b0;

    // Reset during EXEC
    bus.instr_valid  = 1'b1;
    bus.instr        = 20'h4_07_09;
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk("exec_abort_en", 32'(bus.exec_en), 32'd1);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("exec_abort_en0", 32'(bus.exec_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("exec_abort_rv", 32'(bus.result_valid), 32'd0);
    chk("exec_abort_cnt", 32'(bus.instr_cnt), 32'd0);
    exp_cnt = 0;

    // Random traffic through counter wrap
    for (int i = 0; i < 256; i++) run_instr(20'($urandom), $urandom_range(0, 2));
    chk("wrap_cnt", 32'(bus.instr_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
